block_sigma_calc: RTL
=====================

Name: block_sigma_calc

Overview:
- Upstream statistics stage that feeds the watermark strength divider.
- Accepts one 8x8 luminance block as a raster stream of 64 pixels and buffers the block internally.
- Computes block mean and block activity sigma_k, defined as the sum of |pixel - mean|, then presents both with a valid/ready handshake.
- sigma_k (14 bit) is the divisor for the downstream divider; flat_blk warns of a zero divisor.

Parameters:
- PIX_W, 8, pixel width in bits; the design is verified only at 8.
- BLK_LOG2, 6, log2 of pixels per block; 64 pixels, mean = sum >> BLK_LOG2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- pix_in  input  PIX_W  pixel data, raster order within the block.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_ready  output  1  block accepts a pixel this cycle.
- sigma_k  output  14  sum of absolute deviations from the block mean.
- mean_out  output  PIX_W  block mean, truncated.
- flat_blk  output  1  sigma_k == 0.
- out_valid  output  1  sigma_k, mean_out and flat_blk are valid.
- out_ready  input  1  downstream consumes the result.

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- rst forces state LOAD and clears the pixel counter, sum, accumulator, sigma_k, mean_out, flat_blk and out_valid to 0.
- pix_ready is decoded from state only: it is 1 whenever state == LOAD and rst is low.
- Reset mid-operation discards any partial block and any pending result. The buffer contents need no clearing.
- FSM states: LOAD, CALC, DONE.
- LOAD:
  - A pixel is accepted when pix_valid && pix_ready.
  - Each accepted pixel is written to buffer[cnt] and added to a 14-bit sum (max 64*255 = 16320, no overflow). cnt then increments.
  - Gaps in pix_valid are allowed and do not advance cnt.
  - On acceptance of the pixel with cnt == 63: go to CALC and clear cnt and the accumulator.
- CALC:
  - mean = sum[13:6], truncated and held for the whole pass.
  - Each cycle, read buffer[cnt] and add |buffer[cnt] - mean| to a 14-bit accumulator; cnt increments.
  - The accumulator cannot overflow: the worst case is 64*255 = 16320.
  - After cnt == 63 has been accumulated: register sigma_k, mean_out, flat_blk and out_valid = 1, then go to DONE.
- Latency: if the last pixel is accepted at rising edge T, CALC occupies T+1..T+64 and out_valid is 1 starting at edge T+65. This holds independent of input gaps.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - When out_valid && out_ready: drop out_valid next cycle, clear sum and cnt, and go to LOAD.
  - pix_ready is 1 in the cycle after the handshake. No pixel is accepted in the handshake cycle itself.
- pix_ready = 0 throughout CALC and DONE. pix_valid is ignored there, and the upstream must hold its data.
- out_ready is ignored while out_valid = 0.
- flat_blk is registered together with sigma_k. The downstream divider must not be fed a 0 divisor without checking it.
- Abs-diff arithmetic uses a signed (PIX_W+1)-bit difference, then magnitude, zero-extended to 14 bits.

Test Plan:
- Flat block, all 64 pixels = 100, out_ready = 1 → mean_out = 100, sigma_k = 0, flat_blk = 1. out_valid rises exactly 65 cycles after the last accepted pixel.
- Alternating 0/255 (checkerboard) → sum 8160, mean_out = 127, sigma_k = 32*127 + 32*128 = 8160, flat_blk = 0.
- Ramp pixel i = i (0..63) → mean_out = 31 (2016 >> 6), sigma_k = 496 + 528 = 1024.
- All pixels 255 → mean_out = 255, sigma_k = 0, flat_blk = 1. Confirms the sum reaches 16320 without wrap.
- Backpressure and random pix_valid gaps:
  - Hold out_ready = 0 for 10 cycles → out_valid stays 1, outputs are stable, pix_ready = 0.
  - Release out_ready → pix_ready = 1 the next cycle.
  - A second block (ramp) is sent back-to-back → second result is 1024, with no carry-over from the first block.
- Assert rst for one cycle after 30 pixels of a ramp block → all outputs are 0 and pix_ready = 1 the following cycle. A fresh full checkerboard block then yields sigma_k = 8160, mean_out = 127.

Source files
------------

// File: rtl/block_sigma_calc.sv
// block_sigma_calc
//   Buffers one 8x8 luminance block (64 pixels, raster order), then computes
//   the block mean and the activity sigma_k = sum |pixel - mean| for the
//   watermark strength divider. Results leave through a valid/ready handshake.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   pix_in/pix_valid    pixel stream in; pix_ready is high only in LOAD
//   sigma_k             14-bit sum of absolute deviations (divider divisor)
//   mean_out            truncated block mean
//   flat_blk            sigma_k == 0, i.e. a zero divisor downstream
//   out_valid/out_ready result handshake
module block_sigma_calc #(
  parameter int PIX_W    = 8,
  parameter int BLK_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [13:0]      sigma_k,
  output logic [PIX_W-1:0] mean_out,
  output logic             flat_blk,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NPIX = 1 << BLK_LOG2;
  localparam int AW   = 14;

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [PIX_W-1:0]    buffer [NPIX];
  logic [BLK_LOG2-1:0] cnt;
  logic [AW-1:0]       sum, acc, acc_nxt;
  logic [PIX_W-1:0]    mean, rdata;
  logic                rd_vld, rd_last, rd_done;
  logic                pix_acc;
  logic signed [PIX_W:0] diff;
  logic [PIX_W:0]        mag;

  assign pix_ready = (state == LOAD) && !rst;
  assign pix_acc   = pix_valid && pix_ready;
  // sum is frozen during CALC, so the mean is stable for the whole pass
  assign mean      = sum[BLK_LOG2 +: PIX_W];

  // signed (PIX_W+1)-bit difference, then magnitude (max 255, never -256)
  assign diff    = $signed({1'b0, rdata}) - $signed({1'b0, mean});
  assign mag     = diff[PIX_W] ? -diff : diff;
  assign acc_nxt = acc + AW'(mag);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (pix_acc && (&cnt)) state_nxt = CALC;
      CALC:    if (rd_vld && rd_last) state_nxt = DONE;
      // out_valid is always 1 in DONE, so out_ready alone completes it
      DONE:    if (out_ready)         state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Block buffer: no reset, registered read so it maps onto RAM
  always_ff @(posedge clk) begin
    if (pix_acc) buffer[cnt] <= pix_in;
    if (state == CALC && !rd_done) rdata <= buffer[cnt];
  end

  // CALC is a two-stage pass: read buffer[cnt] into rdata, accumulate the
  // following cycle. rd_vld/rd_last track which rdata is live and final.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sum       <= '0;
      acc       <= '0;
      sigma_k   <= '0;
      mean_out  <= '0;
      flat_blk  <= 1'b0;
      out_valid <= 1'b0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          rd_vld  <= 1'b0;
          rd_last <= 1'b0;
          rd_done <= 1'b0;
          if (pix_acc) begin
            sum <= sum + AW'(pix_in);
            // cnt wraps 63 -> 0, which is the clear needed on entering CALC
            cnt <= cnt + 1'b1;
            if (&cnt) acc <= '0;
          end
        end
        CALC: begin
          if (!rd_done) begin
            cnt     <= cnt + 1'b1;
            rd_last <= &cnt;
            rd_done <= &cnt;
          end
          rd_vld <= !rd_done;
          if (rd_vld) begin
            acc <= acc_nxt;
            if (rd_last) begin
              sigma_k   <= acc_nxt;
              mean_out  <= mean;
              flat_blk  <= (acc_nxt == '0);
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
